// File: rtl/ldpc_mem_pkg.sv
// Shared constants for the message-RAM read-modify-write controller: state encoding, default sizes, message range.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional saturating arithmetic is selected by the RMW_SAT_EN macro in ldpc_sat_add.
package ldpc_mem_pkg;

    localparam int W_DEF            = 6;
    localparam int ADDRESSWIDTH_DEF = 9;
    localparam int MEMDEPTH_DEF     = 16;

    localparam int MSG_MAX = (1 << (W_DEF - 1)) - 1;
    localparam int MSG_MIN = -(1 << (W_DEF - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ldpc_sat_add.sv
// Signed W-bit message add with overflow detect; clamps when RMW_SAT_EN is defined, wraps otherwise.
// Latency: combinational. Backpressure: none.
// Overflow is reported in both builds.
module ldpc_sat_add
    import ldpc_mem_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

`ifdef RMW_SAT_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    logic [W:0] full;

    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        // Sign bit disagreeing with the extension bit means the W+1-bit result left the W-bit range.
        ovf  = full[W] ^ full[W-1];
`ifdef RMW_SAT_EN
        if (ovf) begin
            sum = full[W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = full[W-1:0];
        end
`else
        sum = full[W-1:0];
`endif
    end

endmodule

// File: rtl/ldpc_mem_rmw_ctrl.sv
// Sweeps message RAM 0..len-1: async read, add upstream update, registered write-back one cycle later.
// Latency: 1 location/cycle, N+2 cycles start->done. Backpressure: stalls while upd_valid is low.
// RMW_SAT_EN selects saturating instead of wrapping arithmetic (see ldpc_sat_add).
module ldpc_mem_rmw_ctrl
    import ldpc_mem_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEF,
    parameter int MEMDEPTH     = MEMDEPTH_DEF
) (
    input  logic                    memclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDRESSWIDTH:0]   len,
    input  logic [W-1:0]            upd_in,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    ram_en,
    output logic [ADDRESSWIDTH-1:0] ram_ra,
    output logic                    ram_rd_in,
    input  logic [W-1:0]            ram_dout,
    output logic [ADDRESSWIDTH-1:0] ram_wa,
    output logic                    ram_wr_in,
    output logic [W-1:0]            ram_din,
    output logic                    ovf_flag
);

    localparam logic [ADDRESSWIDTH:0] DEPTH = (ADDRESSWIDTH + 1)'(MEMDEPTH);

    state_t                  state;
    logic [ADDRESSWIDTH-1:0] cnt;
    logic [ADDRESSWIDTH:0]   len_q;
    logic                    wb_valid;
    logic [W-1:0]            sum;
    logic                    sum_ovf;
    logic                    last;

    ldpc_sat_add #(.W(W)) u_add (
        .a   (ram_dout),
        .b   (upd_in),
        .sum (sum),
        .ovf (sum_ovf)
    );

    assign ram_en    = ~rst;
    assign ram_rd_in = ~rst && (state == ST_RUN);
    assign ram_ra    = ram_rd_in ? cnt : '0;
    assign upd_ready = ram_rd_in && upd_valid;
    assign busy      = ~rst && ((state == ST_RUN) || (state == ST_FLUSH));
    // A write still in the pipe when reset arrives is dropped rather than landing.
    assign ram_wr_in = wb_valid && ~rst;
    assign last      = ({1'b0, cnt} == (len_q - 1'b1));

    always_ff @(posedge memclk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            len_q    <= '0;
            ram_wa   <= '0;
            ram_din  <= '0;
            wb_valid <= 1'b0;
            ovf_flag <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            wb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        ovf_flag <= 1'b0;
                        if (len == '0) begin
                            len_q <= '0;
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            len_q <= (len > DEPTH) ? DEPTH : len;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (upd_valid) begin
                        ram_din  <= sum;
                        ram_wa   <= cnt;
                        wb_valid <= 1'b1;
                        cnt      <= cnt + 1'b1;
                        if (sum_ovf) begin
                            ovf_flag <= 1'b1;
                        end
                        if (last) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_mem_rmw_ctrl.sv
// Directed bench for ldpc_mem_rmw_ctrl with a behavioural async-read RAM; expectations hand-computed.
// Covers full sweep, stalls, overflow in either RMW_SAT_EN build, len=0, len clamp and mid-sweep reset.
module tb_ldpc_mem_rmw_ctrl;
    import ldpc_mem_pkg::*;

    localparam int W  = 6;
    localparam int AW = 9;

    logic          memclk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [W-1:0]  upd_in = '0;
    logic          upd_valid = 1'b0;
    logic          upd_ready, busy, done, ram_en, ram_rd_in, ram_wr_in, ovf_flag;
    logic [AW-1:0] ram_ra, ram_wa;
    logic [W-1:0]  ram_dout, ram_din;

    logic signed [W-1:0] mem      [512];
    logic signed [W-1:0] init_val [16];
    logic                load_req = 1'b0;
    logic                clr_req  = 1'b0;
    logic                rd_seen, wr_seen, done_seen;
    int                  wr_log [$];

    int checks = 0;
    int failures = 0;

    always #5 memclk = ~memclk;

    ldpc_mem_rmw_ctrl u_dut (
        .memclk    (memclk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .upd_in    (upd_in),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_ra    (ram_ra),
        .ram_rd_in (ram_rd_in),
        .ram_dout  (ram_dout),
        .ram_wa    (ram_wa),
        .ram_wr_in (ram_wr_in),
        .ram_din   (ram_din),
        .ovf_flag  (ovf_flag)
    );

    assign ram_dout = mem[ram_ra];

    always @(posedge memclk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
        end else if (ram_wr_in) begin
            mem[ram_wa] <= ram_din;
        end
        if (clr_req) begin
            wr_log.delete();
            rd_seen   = 1'b0;
            wr_seen   = 1'b0;
            done_seen = 1'b0;
        end else begin
            if (ram_wr_in) wr_log.push_back(int'(ram_wa));
            if (ram_rd_in) rd_seen = 1'b1;
            if (ram_wr_in) wr_seen = 1'b1;
            if (done) done_seen = 1'b1;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge memclk);
        #1;
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < 16; i++) init_val[i] = W'(i);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic clear_log();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    // Pulses start for one edge, then counts cycles until done (start cycle = 0).
    task automatic run_sweep(input int n, output int lat);
        len   = (AW + 1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int exp_cnt;
    logic v;
    int guard;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        rd_seen = 1'b0; wr_seen = 1'b0; done_seen = 1'b0;

        // Reset state, held in reset
        tick();
        tick();
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_upd_ready", int'(upd_ready), 0);
        check_val("rst_ram_rd_in", int'(ram_rd_in), 0);
        check_val("rst_ram_wr_in", int'(ram_wr_in), 0);
        check_val("rst_ram_en", int'(ram_en), 0);
        check_val("rst_ram_ra", int'(ram_ra), 0);
        check_val("rst_ram_wa", int'(ram_wa), 0);
        check_val("rst_ram_din", int'(ram_din), 0);
        check_val("rst_ovf", int'(ovf_flag), 0);
        rst = 1'b0;
        tick();
        check_val("ram_en_out_of_rst", int'(ram_en), 1);

        // Full sweep of 16, +1 continuous
        preload_ramp();
        clear_log();
        upd_in = 6'd1;
        upd_valid = 1'b1;
        run_sweep(16, lat);
        check_val("t1_latency", lat, 18);
        tick();
        check_val("t1_done_one_cycle", int'(done), 0);
        check_val("t1_busy_after", int'(busy), 0);
        check_val("t1_writes", wr_log.size(), 16);
        for (int i = 0; i < 16; i++) check_val($sformatf("t1_ram%0d", i), int'(mem[i]), i + 1);
        check_val("t1_ovf", int'(ovf_flag), 0);

        // len=4 with upd_valid toggling 1,0,1,0
        clear_log();
        upd_in = 6'd2;
        upd_valid = 1'b0;
        len = 10'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0;
        v = 1'b1;
        guard = 0;
        while (!done && guard < 40) begin
            upd_valid = v;
            #1;
            if (ram_rd_in) begin
                check_val("t2_ram_ra", int'(ram_ra), exp_cnt);
                check_val("t2_upd_ready", int'(upd_ready), int'(v));
                if (v) exp_cnt++;
            end
            v = ~v;
            tick();
            guard++;
        end
        upd_valid = 1'b0;
        check_val("t2_done_seen", int'(done), 1);
        tick();
        check_val("t2_writes", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) check_val($sformatf("t2_wa%0d", i), wr_log[i], i);
        for (int i = 0; i < 4; i++) check_val($sformatf("t2_ram%0d", i), int'(mem[i]), i + 3);
        check_val("t2_ram4_untouched", int'(mem[4]), 5);

        // Overflow: 31+5 and -32+(-1)
        for (int i = 0; i < 16; i++) init_val[i] = '0;
        init_val[0] = 6'sd31;
        init_val[1] = -6'sd32;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        len = 10'd2;
        start = 1'b1;
        upd_in = 6'd5;
        upd_valid = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin
            upd_in = (ram_ra == '0) ? 6'd5 : 6'h3f;
            #1;
            tick();
            guard++;
        end
        check_val("t3_done_seen", int'(done), 1);
        tick();
`ifdef RMW_SAT_EN
        check_val("t3_ram0_sat", int'(mem[0]), MSG_MAX);
        check_val("t3_ram1_sat", int'(mem[1]), MSG_MIN);
`else
        check_val("t3_ram0_wrap", int'(mem[0]), -28);
        check_val("t3_ram1_wrap", int'(mem[1]), 31);
`endif
        check_val("t3_ovf", int'(ovf_flag), 1);

        // len=0: done next cycle, no RAM traffic, ovf cleared by start
        clear_log();
        run_sweep(0, lat);
        check_val("t4_latency", lat, 1);
        check_val("t4_ovf_cleared", int'(ovf_flag), 0);
        tick();
        check_val("t4_done_one_cycle", int'(done), 0);
        tick();
        check_val("t4_rd_seen", int'(rd_seen), 0);
        check_val("t4_wr_seen", int'(wr_seen), 0);

        // len=40 clamps to 16 locations
        clear_log();
        upd_in = 6'd0;
        upd_valid = 1'b1;
        run_sweep(40, lat);
        check_val("t5_latency", lat, 18);
        tick();
        check_val("t5_writes", wr_log.size(), 16);
        if (wr_log.size() == 16) check_val("t5_last_wa", wr_log[15], 15);

        // Reset at cnt=5 of a 16-location sweep
        preload_ramp();
        clear_log();
        upd_in = 6'd1;
        len = 10'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (ram_ra != 9'd5 && guard < 30) begin
            tick();
            guard++;
        end
        check_val("t6_reached_cnt5", int'(ram_ra), 5);
        rst = 1'b1;
        #1;
        check_val("t6_wr_gated_in_rst", int'(ram_wr_in), 0);
        tick();
        rst = 1'b0;
        #1;
        check_val("t6_busy", int'(busy), 0);
        check_val("t6_ram_wr_in", int'(ram_wr_in), 0);
        check_val("t6_ram_rd_in", int'(ram_rd_in), 0);
        for (int i = 0; i < 20; i++) tick();
        check_val("t6_no_done", int'(done_seen), 0);
        for (int i = 0; i < 4; i++) check_val($sformatf("t6_ram%0d", i), int'(mem[i]), i + 1);
        for (int i = 5; i < 16; i++) check_val($sformatf("t6_ram%0d", i), int'(mem[i]), i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
